cart_mem_arbiter: RTL and testbench

- Sits directly downstream of the mapper stage. It consumes the mapper's prg_addr/prg_oe and chr_addr/chr_ce/chr_oe/chr_we and turns them into single-port memory transactions (SDRAM/PSRAM controller side).
- Works in the fast system clock domain: it synchronises the slow cartridge-bus strobes, detects the start of each access, arbitrates CHR over PRG, and holds returned bytes for the cartridge data drivers.

---
 rtl/cart_mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: converts mapper PRG/CHR bus strobes (slow, asynchronous)
// into single-port memory transactions in the fast clock domain. CHR has
// strict priority over PRG; each channel keeps one pending slot and a sticky
// overrun flag for accesses that were replaced before they could be issued.
module cart_mem_arbiter #(
  parameter int ADDR_BITS   = 22,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m2,
  input  logic [ADDR_BITS-1:0] prg_addr,
  input  logic                 prg_oe,
  input  logic [ADDR_BITS-1:0] chr_addr,
  input  logic                 chr_ce,
  input  logic                 chr_oe,
  input  logic                 chr_we,
  input  logic [7:0]           ppu_data_in,
  output logic [7:0]           prg_data,
  output logic [7:0]           chr_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 prg_overrun,
  output logic                 chr_overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} st_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic                 we;
    logic [7:0]           wdata;
    logic                 vld;
  } chr_slot_t;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers and edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] m2_sync_q, rd_sync_q, wr_sync_q;
  logic                   m2_prev_q, rd_prev_q, wr_prev_q;
  logic                   m2_s, rd_s, wr_s;
  logic                   chr_rd, chr_wr;
  logic                   prg_trig, rd_rise, wr_rise, chr_trig;

  assign chr_rd = chr_ce & chr_oe;
  assign chr_wr = chr_ce & chr_we;

  // Shift each raw strobe through its synchroniser chain, keep last stage history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_sync_q <= '0;
      rd_sync_q <= '0;
      wr_sync_q <= '0;
      m2_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      m2_sync_q <= {m2_sync_q[SYNC_STAGES-2:0], m2};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], chr_rd};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], chr_wr};
      m2_prev_q <= m2_s;
      rd_prev_q <= rd_s;
      wr_prev_q <= wr_s;
    end
  end

  assign m2_s     = m2_sync_q[SYNC_STAGES-1];
  assign rd_s     = rd_sync_q[SYNC_STAGES-1];
  assign wr_s     = wr_sync_q[SYNC_STAGES-1];
  // Address/data lines are stable for the whole strobe, so they are sampled raw.
  assign prg_trig = m2_s & ~m2_prev_q & prg_oe;
  assign rd_rise  = rd_s & ~rd_prev_q;
  assign wr_rise  = wr_s & ~wr_prev_q;
  assign chr_trig = rd_rise | wr_rise;

  // ---------------------------------------------------------------------------
  // Pending slots and arbitration
  // ---------------------------------------------------------------------------
  st_e                  state_q, state_d;
  chr_slot_t            chr_slot_q, chr_slot_d;
  logic [ADDR_BITS-1:0] prg_slot_addr_q, prg_slot_addr_d;
  logic                 prg_slot_vld_q, prg_slot_vld_d;
  logic                 prg_ovr_q, prg_ovr_d, chr_ovr_q, chr_ovr_d;
  logic                 pick_chr, pick_prg;

  assign pick_chr = (state_q == IDLE) &  chr_slot_q.vld;
  assign pick_prg = (state_q == IDLE) & ~chr_slot_q.vld & prg_slot_vld_q;

  // Slot next-state: a pick empties the slot, a trigger refills it; a trigger
  // landing on a slot that is still waiting (not being picked) is an overrun.
  always_comb begin
    chr_slot_d      = chr_slot_q;
    chr_ovr_d       = chr_ovr_q;
    prg_slot_addr_d = prg_slot_addr_q;
    prg_slot_vld_d  = prg_slot_vld_q;
    prg_ovr_d       = prg_ovr_q;
    if (pick_chr) chr_slot_d.vld = 1'b0;
    if (pick_prg) prg_slot_vld_d = 1'b0;
    if (chr_trig) begin
      if (chr_slot_q.vld && !pick_chr) chr_ovr_d = 1'b1;
      chr_slot_d.addr  = chr_addr;
      chr_slot_d.we    = wr_rise;
      chr_slot_d.wdata = ppu_data_in;
      chr_slot_d.vld   = 1'b1;
    end
    if (prg_trig) begin
      if (prg_slot_vld_q && !pick_prg) prg_ovr_d = 1'b1;
      prg_slot_addr_d = prg_addr;
      prg_slot_vld_d  = 1'b1;
    end
  end

  // Register pending slots and sticky overrun flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chr_slot_q      <= '0;
      prg_slot_addr_q <= '0;
      prg_slot_vld_q  <= 1'b0;
      prg_ovr_q       <= 1'b0;
      chr_ovr_q       <= 1'b0;
    end else begin
      chr_slot_q      <= chr_slot_d;
      prg_slot_addr_q <= prg_slot_addr_d;
      prg_slot_vld_q  <= prg_slot_vld_d;
      prg_ovr_q       <= prg_ovr_d;
      chr_ovr_q       <= chr_ovr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  logic [ADDR_BITS-1:0] fl_addr_q;
  logic                 fl_we_q;
  logic [7:0]           fl_wdata_q;
  logic                 fl_chr_q;
  logic [7:0]           prg_data_q, chr_data_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: pick a slot, present it for one cycle, then wait for ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_chr || pick_prg) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request outputs, driven only while a transaction is outstanding
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q != IDLE) begin
      mem_req   = 1'b1;
      mem_we    = fl_we_q;
      mem_addr  = fl_addr_q;
      mem_wdata = fl_wdata_q;
    end
  end

  // In-flight register: captured at pick time and held through WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_addr_q  <= '0;
      fl_we_q    <= 1'b0;
      fl_wdata_q <= '0;
      fl_chr_q   <= 1'b0;
    end else if (pick_chr) begin
      fl_addr_q  <= chr_slot_q.addr;
      fl_we_q    <= chr_slot_q.we;
      fl_wdata_q <= chr_slot_q.wdata;
      fl_chr_q   <= 1'b1;
    end else if (pick_prg) begin
      fl_addr_q  <= prg_slot_addr_q;
      fl_we_q    <= 1'b0;
      fl_wdata_q <= '0;
      fl_chr_q   <= 1'b0;
    end
  end

  // Read data capture on ack; acks outside WAIT are stray and ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prg_data_q <= '0;
      chr_data_q <= '0;
    end else if (state_q == WAIT && mem_ack && !fl_we_q) begin
      if (fl_chr_q) chr_data_q <= mem_rdata;
      else          prg_data_q <= mem_rdata;
    end
  end

  assign prg_data    = prg_data_q;
  assign chr_data    = chr_data_q;
  assign prg_overrun = prg_ovr_q;
  assign chr_overrun = chr_ovr_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter: drives bus strobes, acts as the memory
// and compares against hand-computed values.
module tb_cart_mem_arbiter;
  localparam int AW = 22;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          m2 = 1'b0, prg_oe = 1'b0;
  logic [AW-1:0] prg_addr = '0, chr_addr = '0;
  logic          chr_ce = 1'b0, chr_oe = 1'b0, chr_we = 1'b0;
  logic [7:0]    ppu_data_in = '0;
  logic [7:0]    prg_data, chr_data;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic          prg_overrun, chr_overrun;

  int n_chk = 0, n_pass = 0;

  cart_mem_arbiter #(.ADDR_BITS(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .m2(m2), .prg_addr(prg_addr), .prg_oe(prg_oe),
    .chr_addr(chr_addr), .chr_ce(chr_ce), .chr_oe(chr_oe), .chr_we(chr_we),
    .ppu_data_in(ppu_data_in), .prg_data(prg_data), .chr_data(chr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .prg_overrun(prg_overrun), .chr_overrun(chr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Wait (bounded) for mem_req, record its fields, ack after dly cycles
  task automatic serve(input logic [7:0] rd, input int dly, output int lat,
                       output logic [AW-1:0] a, output logic w, output logic [7:0] wd);
    lat = 0;
    while (!mem_req && lat < 60) begin @(negedge clk); lat++; end
    a = mem_addr; w = mem_we; wd = mem_wdata;
    repeat (dly - 1) @(negedge clk);
    mem_rdata = rd; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    int            lat;
    logic [AW-1:0] a;
    logic          w;
    logic [7:0]    wd;
    logic          any;

    // Reset, then 100 quiet cycles
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    any = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any |= mem_req | (|prg_data) | (|chr_data) | prg_overrun | chr_overrun;
    end
    chk("idle_quiet", any, 0);
    chk("rst_prg_data", prg_data, 8'h00);
    chk("rst_chr_data", chr_data, 8'h00);

    // PRG read, ack 5 cycles after req
    prg_addr = 22'h004ABC; prg_oe = 1'b1; m2 = 1'b1;
    serve(8'hA5, 5, lat, a, w, wd);
    chk("prg_latency", lat, 4);
    chk("prg_addr", a, 22'h004ABC);
    chk("prg_we", w, 0);
    chk("prg_data", prg_data, 8'hA5);
    chk("prg_req_drop", mem_req, 0);
    m2 = 1'b0; prg_oe = 1'b0;
    repeat (5) @(negedge clk);

    // CHR write
    chr_addr = 22'h001234; ppu_data_in = 8'h3C; chr_ce = 1'b1; chr_we = 1'b1;
    serve(8'hFF, 3, lat, a, w, wd);
    chk("chrw_we", w, 1);
    chk("chrw_addr", a, 22'h001234);
    chk("chrw_wdata", wd, 8'h3C);
    chk("chrw_chr_data", chr_data, 8'h00);
    chr_ce = 1'b0; chr_we = 1'b0;
    repeat (5) @(negedge clk);

    // Simultaneous PRG and CHR reads: CHR first, PRG right after
    prg_addr = 22'h000777; prg_oe = 1'b1; m2 = 1'b1;
    chr_addr = 22'h000555; chr_ce = 1'b1; chr_oe = 1'b1;
    serve(8'h11, 3, lat, a, w, wd);
    chk("both_first_addr", a, 22'h000555);
    serve(8'h22, 3, lat, a, w, wd);
    chk("both_prg_lat", lat, 1);
    chk("both_second_addr", a, 22'h000777);
    chk("both_chr_data", chr_data, 8'h11);
    chk("both_prg_data", prg_data, 8'h22);
    m2 = 1'b0; prg_oe = 1'b0; chr_ce = 1'b0; chr_oe = 1'b0;
    repeat (5) @(negedge clk);

    // CHR overrun while PRG is stalled in WAIT
    prg_addr = 22'h000999; prg_oe = 1'b1; m2 = 1'b1;
    lat = 0;
    while (!mem_req && lat < 60) begin @(negedge clk); lat++; end
    chk("ovr_prg_req", mem_req, 1);
    chr_addr = 22'h000100; chr_ce = 1'b1; chr_oe = 1'b1;
    repeat (6) @(negedge clk);
    chr_oe = 1'b0;
    repeat (5) @(negedge clk);
    chr_addr = 22'h000200; chr_oe = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovr_chr_flag", chr_overrun, 1);
    chk("ovr_prg_flag", prg_overrun, 0);
    chk("ovr_held_addr", mem_addr, 22'h000999);
    mem_rdata = 8'h33; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("ovr_prg_data", prg_data, 8'h33);
    serve(8'h44, 2, lat, a, w, wd);
    chk("ovr_chr_addr", a, 22'h000200);
    chk("ovr_chr_data", chr_data, 8'h44);
    any = 1'b0;
    repeat (10) begin @(negedge clk); any |= mem_req; end
    chk("ovr_single_issue", any, 0);
    m2 = 1'b0; prg_oe = 1'b0; chr_ce = 1'b0; chr_oe = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during WAIT, then a stray ack
    prg_addr = 22'h000AAA; prg_oe = 1'b1; m2 = 1'b1;
    lat = 0;
    while (!mem_req && lat < 60) begin @(negedge clk); lat++; end
    chk("rstw_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_req_async", mem_req, 0);
    chk("rstw_ovr", {30'd0, prg_overrun, chr_overrun}, 0);
    chk("rstw_data", {prg_data, chr_data}, 16'h0000);
    m2 = 1'b0; prg_oe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mem_rdata = 8'hEE; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("stray_prg_data", prg_data, 8'h00);
    chk("stray_chr_data", chr_data, 8'h00);
    chk("stray_req", mem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
